// File: rtl/perceptron_trainer_if.sv
// Streaming bundle between the trainer (master) and a perceptron (slave):
// forward argument/result, backward error/feedback, plus the learning enable.
interface perceptron_trainer_if #(
  parameter int N         = 2,
  parameter int ARG_WIDTH = 8,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int FBK_WIDTH = 16
);
  logic                   en;
  logic                   arg_valid;
  logic                   arg_ready;
  logic [N*ARG_WIDTH-1:0] arg_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [RES_WIDTH-1:0]   res_data;
  logic                   err_valid;
  logic                   err_ready;
  logic [ERR_WIDTH-1:0]   err_data;
  logic                   fbk_valid;
  logic                   fbk_ready;
  logic [N*FBK_WIDTH-1:0] fbk_data;

  modport master (
    output en,
    output arg_valid, arg_data, input  arg_ready,
    input  res_valid, res_data, output res_ready,
    output err_valid, err_data, input  err_ready,
    input  fbk_valid, fbk_data, output fbk_ready
  );

  modport slave (
    input  en,
    input  arg_valid, arg_data, output arg_ready,
    output res_valid, res_data, input  res_ready,
    input  err_valid, err_data, output err_ready,
    output fbk_valid, fbk_data, input  fbk_ready
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Training sequencer for a streaming perceptron: runs the programmed number of
// epochs over a small sample table, then one evaluation pass counting mismatches.
module perceptron_trainer #(
  parameter  int N         = 2,
  parameter  int ARG_WIDTH = 8,
  parameter  int RES_WIDTH = 8,
  parameter  int ERR_WIDTH = 16,
  parameter  int FBK_WIDTH = 16,
  parameter  int SAMPLES   = 4,
  localparam int IDX_W     = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
  localparam int MISS_W    = $clog2(SAMPLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  input  logic [IDX_W-1:0]       ld_addr,
  input  logic [N*ARG_WIDTH-1:0] ld_arg,
  input  logic [RES_WIDTH-1:0]   ld_tgt,
  input  logic                   start,
  input  logic [15:0]            epochs,
  output logic                   busy,
  output logic                   done,
  output logic [MISS_W-1:0]      miss,
  perceptron_trainer_if.master   bus
);
  if (ERR_WIDTH < RES_WIDTH + 1 || SAMPLES < 1 || FBK_WIDTH < 1) begin : gBadParams
    $error("perceptron_trainer: ERR_WIDTH must exceed RES_WIDTH and SAMPLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, TRN_ARG, TRN_RES, TRN_ERR, TRN_FBK, EVL_ARG, EVL_RES, DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            epochCnt_q, epochCnt_d;
  logic [15:0]            epochs_q, epochs_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic                   en_q, en_d;
  logic                   argValid_q, argValid_d;
  logic                   errValid_q, errValid_d;

  logic [N*ARG_WIDTH-1:0] argTab [SAMPLES];
  logic [RES_WIDTH-1:0]   tgtTab [SAMPLES];

  logic                   argFire, resFire, errFire, fbkFire, idxLast;
  logic [ERR_WIDTH-1:0]   errCalc;
  logic [15:0]            epochNext;

  // The table is deliberately outside the reset domain so a reset keeps the samples.
  always_ff @(posedge clk) begin
    if (ld_valid && !busy && ({1'b0, ld_addr} < (IDX_W + 1)'(SAMPLES))) begin
      argTab[ld_addr] <= ld_arg;
      tgtTab[ld_addr] <= ld_tgt;
    end
  end

  assign argFire   = argValid_q && bus.arg_ready;
  assign resFire   = bus.res_valid && bus.res_ready;
  assign errFire   = errValid_q && bus.err_ready;
  assign fbkFire   = bus.fbk_valid && bus.fbk_ready;
  assign idxLast   = (idx_q == LAST_IDX);
  assign epochNext = epochCnt_q + 16'd1;
  assign errCalc   = {{(ERR_WIDTH - RES_WIDTH){1'b0}}, tgtTab[idx_q]}
                   - {{(ERR_WIDTH - RES_WIDTH){1'b0}}, bus.res_data};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    epochCnt_d = epochCnt_q;
    epochs_d   = epochs_q;
    err_d      = err_q;
    miss_d     = miss_q;
    en_d       = en_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          epochs_d   = epochs;
          epochCnt_d = '0;
          idx_d      = '0;
          miss_d     = '0;
          en_d       = (epochs != 16'd0);
          state_d    = (epochs != 16'd0) ? TRN_ARG : EVL_ARG;
        end
      end
      TRN_ARG: if (argFire) state_d = TRN_RES;
      TRN_RES: begin
        if (resFire) begin
          err_d   = errCalc;
          state_d = TRN_ERR;
        end
      end
      TRN_ERR: if (errFire) state_d = TRN_FBK;
      TRN_FBK: begin
        if (fbkFire) begin
          if (idxLast) begin
            idx_d      = '0;
            epochCnt_d = epochNext;
            if (epochNext == epochs_q) begin
              en_d    = 1'b0;
              state_d = EVL_ARG;
            end else begin
              state_d = TRN_ARG;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = TRN_ARG;
          end
        end
      end
      EVL_ARG: if (argFire) state_d = EVL_RES;
      EVL_RES: begin
        if (resFire) begin
          if (errCalc != '0) miss_d = miss_q + MISS_W'(1);
          if (idxLast) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = EVL_ARG;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Valids are decoded from the next state so they leave a flop, not a decoder.
    argValid_d = (state_d == TRN_ARG) || (state_d == EVL_ARG);
    errValid_d = (state_d == TRN_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      epochCnt_q <= '0;
      epochs_q   <= '0;
      err_q      <= '0;
      miss_q     <= '0;
      en_q       <= 1'b0;
      argValid_q <= 1'b0;
      errValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      epochCnt_q <= epochCnt_d;
      epochs_q   <= epochs_d;
      err_q      <= err_d;
      miss_q     <= miss_d;
      en_q       <= en_d;
      argValid_q <= argValid_d;
      errValid_q <= errValid_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign miss          = miss_q;
  assign bus.en        = en_q;
  assign bus.arg_valid = argValid_q;
  assign bus.arg_data  = argTab[idx_q];
  assign bus.res_ready = (state_q == TRN_RES) || (state_q == EVL_RES);
  assign bus.err_valid = errValid_q;
  assign bus.err_data  = err_q;
  assign bus.fbk_ready = (state_q == TRN_FBK);
endmodule
